// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal sync response path.
package fractal_sync_pkg;

  typedef logic fsync_rsp_t;

  // Rotating pointers need at least one bit even with a single port.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_rsp_channel.sv
// One response channel: rotating-priority arbiter over IN_PORTS FIFOs
// feeding OUT_PORTS registered valid/ready output slots.
module fractal_sync_rsp_channel
  import fractal_sync_pkg::*;
#(
  parameter int unsigned IN_PORTS  = 4,
  parameter int unsigned OUT_PORTS = 2,
  parameter type fsync_rsp_t = fractal_sync_pkg::fsync_rsp_t
)(
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic [IN_PORTS-1:0]        pop_o,
  input  logic [IN_PORTS-1:0]        empty_i,
  input  fsync_rsp_t [IN_PORTS-1:0]  element_i,
  output logic [OUT_PORTS-1:0]       valid_o,
  input  logic [OUT_PORTS-1:0]       ready_i,
  output fsync_rsp_t [OUT_PORTS-1:0] element_o
);

  localparam int unsigned PW = ptr_width(IN_PORTS);

  logic [PW-1:0]                 ptr_q, ptr_d;
  logic [OUT_PORTS-1:0]          valid_q, free, load;
  fsync_rsp_t [OUT_PORTS-1:0]    elem_q, elem_d;
  logic [IN_PORTS-1:0]           grant;
  logic [OUT_PORTS-1:0][PW-1:0]  cand;

  assign free = ~valid_q | ready_i;

  // First pass ranks requesters in rotated order; second pass hands the
  // n-th ranked requester to the n-th free slot.
  always_comb begin
    int unsigned nreq, nfree, idx, last;
    cand   = '0;
    grant  = '0;
    load   = '0;
    elem_d = elem_q;
    ptr_d  = ptr_q;
    nreq   = 0;
    nfree  = 0;
    idx    = 0;
    last   = 0;
    for (int unsigned i = 0; i < IN_PORTS; i++) begin
      idx = (32'(ptr_q) + i) % IN_PORTS;
      if (!empty_i[idx] && nreq < OUT_PORTS) begin
        cand[nreq] = PW'(idx);
        nreq++;
      end
    end
    for (int unsigned k = 0; k < OUT_PORTS; k++) begin
      if (free[k]) begin
        if (nfree < nreq) begin
          load[k]            = 1'b1;
          elem_d[k]          = element_i[cand[nfree]];
          grant[cand[nfree]] = 1'b1;
          last               = 32'(cand[nfree]);
        end else begin
          elem_d[k] = '0;
        end
        nfree++;
      end
    end
    if (|load) ptr_d = (last == IN_PORTS - 1) ? '0 : PW'(last + 1);
  end

  assign pop_o     = grant & {IN_PORTS{~rst_i}};
  assign valid_o   = valid_q;
  assign element_o = elem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      elem_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= load | (valid_q & ~free);
      elem_q  <= elem_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/fractal_sync_rsp_dispatcher.sv
// Response dispatcher: two independent channels (en, ws) draining response
// FIFOs into registered output slots.
module fractal_sync_rsp_dispatcher
  import fractal_sync_pkg::*;
#(
  parameter int unsigned IN_PORTS  = 4,
  parameter int unsigned OUT_PORTS = 2,
  parameter type fsync_rsp_t = fractal_sync_pkg::fsync_rsp_t
)(
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic [IN_PORTS-1:0]        en_pop_o,
  input  logic [IN_PORTS-1:0]        en_empty_i,
  input  fsync_rsp_t [IN_PORTS-1:0]  en_element_i,
  output logic [IN_PORTS-1:0]        ws_pop_o,
  input  logic [IN_PORTS-1:0]        ws_empty_i,
  input  fsync_rsp_t [IN_PORTS-1:0]  ws_element_i,
  output logic [OUT_PORTS-1:0]       en_valid_o,
  input  logic [OUT_PORTS-1:0]       en_ready_i,
  output fsync_rsp_t [OUT_PORTS-1:0] en_element_o,
  output logic [OUT_PORTS-1:0]       ws_valid_o,
  input  logic [OUT_PORTS-1:0]       ws_ready_i,
  output fsync_rsp_t [OUT_PORTS-1:0] ws_element_o
);

  if (IN_PORTS == 0) begin : g_bad_in
    $error("IN_PORTS must be > 0");
  end
  if (OUT_PORTS == 0 || OUT_PORTS > IN_PORTS) begin : g_bad_out
    $error("OUT_PORTS must be > 0 and <= IN_PORTS");
  end

  fractal_sync_rsp_channel #(
    .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS), .fsync_rsp_t(fsync_rsp_t)
  ) i_en (
    .clk_i(clk_i), .rst_i(rst_i),
    .pop_o(en_pop_o), .empty_i(en_empty_i), .element_i(en_element_i),
    .valid_o(en_valid_o), .ready_i(en_ready_i), .element_o(en_element_o)
  );

  fractal_sync_rsp_channel #(
    .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS), .fsync_rsp_t(fsync_rsp_t)
  ) i_ws (
    .clk_i(clk_i), .rst_i(rst_i),
    .pop_o(ws_pop_o), .empty_i(ws_empty_i), .element_i(ws_element_i),
    .valid_o(ws_valid_o), .ready_i(ws_ready_i), .element_o(ws_element_o)
  );

endmodule

// File: doc/fractal_sync_rsp_dispatcher.md
Name: fractal_sync_rsp_dispatcher

Overview:
- Response-side counterpart of the fractal sync request path. Drains synchronisation responses from per-port response FIFOs and dispatches them toward the lower tree level.
- Two independent channels: en (east/north) and ws (west/south).
- Each channel uses a rotating-priority arbiter to grant up to OUT_PORTS FIFOs per cycle, pops them, and holds the grants in registered output slots with a valid/ready handshake.

Parameters:
- IN_PORTS, 4, number of response FIFOs per channel (must be > 0).
- OUT_PORTS, 2, number of output slots per channel (must be > 0 and <= IN_PORTS).
- fsync_rsp_t, logic, response element type.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- en_pop_o  out  1 x IN_PORTS  pop strobe to en FIFOs.
- en_empty_i  in  1 x IN_PORTS  en FIFO empty flags.
- en_element_i  in  fsync_rsp_t x IN_PORTS  en FIFO heads.
- ws_pop_o  out  1 x IN_PORTS  pop strobe to ws FIFOs.
- ws_empty_i  in  1 x IN_PORTS  ws FIFO empty flags.
- ws_element_i  in  fsync_rsp_t x IN_PORTS  ws FIFO heads.
- en_valid_o  out  1 x OUT_PORTS  en slot holds a response.
- en_ready_i  in  1 x OUT_PORTS  downstream accepts the en slot.
- en_element_o  out  fsync_rsp_t x OUT_PORTS  en slot content.
- ws_valid_o  out  1 x OUT_PORTS  ws slot holds a response.
- ws_ready_i  in  1 x OUT_PORTS  downstream accepts the ws slot.
- ws_element_o  out  fsync_rsp_t x OUT_PORTS  ws slot content.

Behaviour:
- Both channels are identical and fully independent; the rules below apply per channel.
- Reset (rst_i high, asynchronous):
  - all valid_o = 0, all element_o = '0, ptr_q = 0.
  - pop_o = 0 while reset is asserted, whatever empty_i says.
  - Reset mid-operation discards slot contents; FIFOs are not popped.
- Slot k is free this cycle iff !valid_q[k] || ready_i[k]. A transfer occurs when valid_o & ready_i.
- Combinational arbitration each cycle:
  - Requesters are the ports with !empty_i[j].
  - Scan requesters starting at ptr_q, ascending, wrapping modulo IN_PORTS.
  - Assign them to free slots in ascending slot index; each input is granted at most once per cycle.
  - Number of grants = min(requesters, free slots).
  - pop_o[j] = 1 exactly for granted inputs, in the same cycle.
- Registered update on the clock edge:
  - A granted slot loads element_i[j] and sets valid.
  - A free slot with no grant clears valid and resets element to '0.
  - A non-free slot holds its content.
  - Latency from a FIFO non-empty head to valid_o is 1 cycle.
- Pointer update:
  - If there was at least one grant, ptr_q <= (last granted index + 1) mod IN_PORTS.
  - Otherwise ptr_q holds.
  - Wrap-around case: when the last grant was IN_PORTS-1, ptr_q becomes 0.
- Back-to-back: a slot consumed (ready_i=1) and refilled in the same cycle shows valid_o continuously with the new element; no bubble.
- All requesters empty: no pops; free slots drop valid.
- Full back-pressure (all slots valid, all ready_i = 0): no pops, ptr_q holds, outputs stable.
- en/ws simultaneous activity never interacts.
- IN_PORTS = 1: pointer width is max(1, $clog2(IN_PORTS)) and is held at 0.

Decomposition:
- Shared package fractal_sync_pkg: the fsync_rsp_t typedef and a shared pointer-width helper.
- One sub-module: fractal_sync_rsp_channel. It contains the rotating arbiter, pointer register and output slots. It is instantiated twice, once for en and once for ws.
- The top module is wiring plus parameter assertions.

Test Plan (IN_PORTS=4, OUT_PORTS=2 unless stated):
- Reset: rst_i pulsed mid-traffic with non-empty FIFOs -> valid_o=0, element_o=0, pop_o=0 during reset; after release, first grants come from ports 0 and 1.
- Round-robin: all 4 en FIFOs non-empty, ready=1 -> cycle 1 pops {0,1}, cycle 2 pops {2,3}, cycle 3 pops {0,1}; valid_o high from cycle 2 onward with the matching elements.
- Wrap-around: only ports 3 and 0 non-empty, ptr_q=3 -> slot0 gets port 3, slot1 gets port 0, ptr_q becomes 1.
- Back-pressure: en_ready_i=2'b01 with both slots valid -> only slot0 refilled, one pop; slot1 content unchanged until ready.
- Independence: ws FIFOs all empty, en FIFOs full -> ws_pop_o=0 and ws_valid_o=0 throughout, while en traffic behaves as in the round-robin scenario.
- Single requester: only port 2 non-empty for 3 cycles, ready=1 -> a pop every cycle, always into slot0, ptr_q=3.
